xgmii_loopback_tester: RTL and testbench
========================================

// Module: xgmii_loopback_tester
// PURPOSE
//  Synthesisable XGMII traffic generator and loopback checker for eth_phy_10g bring-up; replaces the fixed bench pattern loop.
//  Drives xgmii_txd/txc into the PHY TX path and compares xgmii_rxd/rxc from the RX path against its own transmit history.
//  Finds loopback latency automatically, holds lock, counts word errors. Single clock domain: loopback is in the tx_clk domain.
// PARAMETERS
//  DATA_WIDTH     64          XGMII data width (multiple of 32)
//  CTRL_WIDTH     DATA_WIDTH/8  XGMII control width
//  DWELL_CYCLES   10          cycles each mode-0 table entry is held (>=1)
//  MAX_LATENCY    15          largest loopback latency searched, in cycles
//  LOCK_COUNT     8           matched data transitions needed to declare lock
//  BAD_LIMIT      4           consecutive mismatches in LOCKED that force re-search
//  ERR_CNT_WIDTH  16          error counter width
// PORTS
//  tx_clk       in   1               clock
//  tx_rst       in   1               synchronous reset, active high
//  cfg_enable   in   1               1 = generate and check
//  cfg_mode     in   2               0 table, 1 counter, 2 PRBS31, 3 idle
//  cfg_clear    in   1               pulse: clear err_count
//  xgmii_txd    out  DATA_WIDTH      to PHY TX
//  xgmii_txc    out  CTRL_WIDTH      to PHY TX
//  xgmii_rxd    in   DATA_WIDTH      from PHY RX
//  xgmii_rxc    in   CTRL_WIDTH      from PHY RX
//  lock         out  1               checker locked to latency
//  latency      out  clog2(MAX_LATENCY+1)  locked latency in cycles
//  err_pulse    out  1               1-cycle pulse per mismatched word while LOCKED
//  err_count    out  ERR_CNT_WIDTH   saturating mismatch count
// BEHAVIOUR
//  Reset: txd=0x07 repeated, txc all-ones, lock=0, latency=0, err_pulse=0, err_count=0.
//   Reset also sets FSM=IDLE, history cleared to idle, PRBS state all-ones.
//  Generator: registered outputs. cfg_enable=0 -> idle (0x07/all-ones txc).
//  Mode 0: 6-entry table, each held DWELL_CYCLES, wraps 5->0:
//   FF../c0, 00../c0, 55../c0, AA../c0, FE../c all-ones, 07../c all-ones.
//  Mode 1: txd = 32-bit counter replicated per 32-bit lane; +1 per cycle, wraps; txc=0.
//  Mode 2: PRBS31 x^31+x^28+1, seed all-ones; advances DATA_WIDTH bits per cycle, MSB first; txc=0.
//  Mode 3: idle; checker can never lock (no transitions). This is legal, not an error.
//  History: shift register hist[0..MAX_LATENCY+1] of {txd,txc}; hist[0] = word on the outputs this cycle.
//  Match(k): {rxd,rxc} == hist[k]. Transition(k): hist[k] != hist[k+1].
//  FSM IDLE -> SEARCH when cfg_enable=1.
//  SEARCH: per-k run counters (k=0..MAX_LATENCY).
//   Match & transition -> +1; match & no transition -> hold; mismatch -> 0.
//   First counter to reach LOCK_COUNT (lowest k on a tie) -> LOCKED; latency=k, lock=1 on the next cycle.
//  LOCKED: compare against hist[latency] every cycle.
//   Mismatch -> err_pulse next cycle; err_count+1, saturating at all-ones.
//   BAD_LIMIT consecutive mismatches -> SEARCH: lock=0, run counters=0, latency holds its last value.
//  Any state, cfg_enable 1->0 -> IDLE next cycle, lock=0; counters and err_count hold.
//  cfg_mode change while enabled -> generator restarts (table index 0, counter 0, PRBS seed) and FSM -> SEARCH.
//  cfg_clear has priority over an increment in the same cycle: the result is 0.
//  The err_pulse for that cycle is still issued.
//  Mismatches in SEARCH/IDLE are never counted.
// TESTING
//  Reset held 3 cycles -> txd=0707..07, txc=FF, lock=0, err_count=0.
//  Mode 0, 2-cycle register loopback -> lock=1 within 8 transitions, latency=2, err_count=0 over 1000 cycles.
//  Mode 2, loopback via eth_phy_10g (scrambler off) -> lock, latency stable, err_count=0.
//  Locked, flip 1 rx bit for 1 cycle -> err_pulse once, err_count=1, lock stays 1.
//  Corrupt 4 consecutive words -> err_count=4, lock=0, then relock at the same latency.
//  ERR_CNT_WIDTH=4, rxd forced to 0 after lock -> err_count saturates at 15.
//  Loopback delay 20 > MAX_LATENCY -> lock stays 0.
//  Mode 3 -> lock stays 0.
//  cfg_clear coincident with an error -> err_count=0.

Source files
------------

// File: rtl/xgmii_loopback_tester.sv
// rtl/xgmii_loopback_tester.sv - XGMII pattern generator with self-aligning loopback checker
module xgmii_loopback_tester #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int DWELL_CYCLES  = 10,
    parameter int MAX_LATENCY   = 15,
    parameter int LOCK_COUNT    = 8,
    parameter int BAD_LIMIT     = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                               tx_clk,
    input  logic                               tx_rst,
    input  logic                               cfg_enable,
    input  logic [1:0]                         cfg_mode,
    input  logic                               cfg_clear,
    output logic [DATA_WIDTH-1:0]              xgmii_txd,
    output logic [CTRL_WIDTH-1:0]              xgmii_txc,
    input  logic [DATA_WIDTH-1:0]              xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0]              xgmii_rxc,
    output logic                               lock,
    output logic [$clog2(MAX_LATENCY+1)-1:0]   latency,
    output logic                               err_pulse,
    output logic [ERR_CNT_WIDTH-1:0]           err_count
);

    localparam int W     = DATA_WIDTH + CTRL_WIDTH;
    localparam int LANES = DATA_WIDTH / 32;
    localparam int LAT_W = $clog2(MAX_LATENCY + 1);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W = $clog2(BAD_LIMIT + 1);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam logic [W-1:0] IDLE_WORD = {{(DATA_WIDTH/8){8'h07}}, {CTRL_WIDTH{1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCKED} state_t;

    state_t state, state_n;
    logic              en_d;
    logic [1:0]        mode_d;
    logic              restart;
    logic [2:0]        tbl_idx, tbl_idx_c, tbl_idx_n;
    logic [DW_W-1:0]   dwell, dwell_c, dwell_n;
    logic [31:0]       cnt, cnt_c, cnt_n;
    logic [30:0]       prbs, prbs_c, prbs_n, prbs_s;
    logic              prbs_b;
    logic [DATA_WIDTH-1:0] gen_data;
    logic [CTRL_WIDTH-1:0] gen_ctrl;
    logic [W-1:0]      hist [0:MAX_LATENCY+1];
    logic [W-1:0]      rx_word, hist_sel;
    logic [RUN_W-1:0]  run [0:MAX_LATENCY];
    logic [RUN_W-1:0]  run_next [0:MAX_LATENCY];
    logic              hit;
    logic [LAT_W-1:0]  hit_k;
    logic              lock_miss, err_hit;
    logic [BAD_W-1:0]  bad;

    // Enabling or switching mode restarts the pattern from its first word.
    assign restart = cfg_enable && (!en_d || (cfg_mode != mode_d));

    always_comb begin
        tbl_idx_c = restart ? 3'd0 : tbl_idx;
        dwell_c   = restart ? '0 : dwell;
        cnt_c     = restart ? 32'd0 : cnt;
        prbs_c    = restart ? '1 : prbs;
        tbl_idx_n = tbl_idx;
        dwell_n   = dwell;
        cnt_n     = cnt;
        prbs_n    = prbs;
        prbs_s    = prbs_c;
        prbs_b    = 1'b0;
        gen_data  = IDLE_WORD[W-1:CTRL_WIDTH];
        gen_ctrl  = '1;
        if (cfg_enable) begin
            case (cfg_mode)
                2'd0: begin
                    case (tbl_idx_c)
                        3'd0:    begin gen_data = {(DATA_WIDTH/8){8'hFF}}; gen_ctrl = '0; end
                        3'd1:    begin gen_data = {(DATA_WIDTH/8){8'h00}}; gen_ctrl = '0; end
                        3'd2:    begin gen_data = {(DATA_WIDTH/8){8'h55}}; gen_ctrl = '0; end
                        3'd3:    begin gen_data = {(DATA_WIDTH/8){8'hAA}}; gen_ctrl = '0; end
                        3'd4:    begin gen_data = {(DATA_WIDTH/8){8'hFE}}; gen_ctrl = '1; end
                        default: begin gen_data = {(DATA_WIDTH/8){8'h07}}; gen_ctrl = '1; end
                    endcase
                    if (dwell_c == DW_W'(DWELL_CYCLES - 1)) begin
                        dwell_n   = '0;
                        tbl_idx_n = (tbl_idx_c == 3'd5) ? 3'd0 : tbl_idx_c + 3'd1;
                    end else begin
                        dwell_n   = dwell_c + 1'b1;
                        tbl_idx_n = tbl_idx_c;
                    end
                end
                2'd1: begin
                    gen_data = {LANES{cnt_c}};
                    gen_ctrl = '0;
                    cnt_n    = cnt_c + 32'd1;
                end
                2'd2: begin
                    // Each output bit is the feedback bit, first bit lands in the MSB.
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        prbs_b = prbs_s[30] ^ prbs_s[27];
                        gen_data[DATA_WIDTH-1-i] = prbs_b;
                        prbs_s = {prbs_s[29:0], prbs_b};
                    end
                    gen_ctrl = '0;
                    prbs_n   = prbs_s;
                end
                default: ;
            endcase
        end
    end

    assign xgmii_txd = hist[0][W-1:CTRL_WIDTH];
    assign xgmii_txc = hist[0][CTRL_WIDTH-1:0];
    assign rx_word   = {xgmii_rxd, xgmii_rxc};
    assign lock      = (state == ST_LOCKED);

    always_comb begin
        hit      = 1'b0;
        hit_k    = '0;
        hist_sel = hist[0];
        for (int k = MAX_LATENCY; k >= 0; k--) begin
            if (rx_word == hist[k]) begin
                run_next[k] = (hist[k] != hist[k+1]) ? run[k] + 1'b1 : run[k];
            end else begin
                run_next[k] = '0;
            end
            if (run_next[k] == RUN_W'(LOCK_COUNT)) begin
                hit   = 1'b1;
                hit_k = LAT_W'(k);
            end
            if (latency == LAT_W'(k)) begin
                hist_sel = hist[k];
            end
        end
        lock_miss = (rx_word != hist_sel);
        err_hit   = cfg_enable && !restart && (state == ST_LOCKED) && lock_miss;
    end

    always_comb begin
        state_n = state;
        if (!cfg_enable) begin
            state_n = ST_IDLE;
        end else if (restart) begin
            state_n = ST_SEARCH;
        end else begin
            case (state)
                ST_IDLE:   state_n = ST_SEARCH;
                ST_SEARCH: if (hit) state_n = ST_LOCKED;
                ST_LOCKED: if (lock_miss && (bad == BAD_W'(BAD_LIMIT - 1))) state_n = ST_SEARCH;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state     <= ST_IDLE;
            en_d      <= 1'b0;
            mode_d    <= 2'd0;
            tbl_idx   <= 3'd0;
            dwell     <= '0;
            cnt       <= 32'd0;
            prbs      <= '1;
            latency   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bad       <= '0;
            for (int i = 0; i <= MAX_LATENCY + 1; i++) hist[i] <= IDLE_WORD;
            for (int k = 0; k <= MAX_LATENCY; k++) run[k] <= '0;
        end else begin
            state   <= state_n;
            en_d    <= cfg_enable;
            mode_d  <= cfg_mode;
            tbl_idx <= tbl_idx_n;
            dwell   <= dwell_n;
            cnt     <= cnt_n;
            prbs    <= prbs_n;
            hist[0] <= {gen_data, gen_ctrl};
            for (int i = 1; i <= MAX_LATENCY + 1; i++) hist[i] <= hist[i-1];
            err_pulse <= err_hit;
            if (cfg_clear) begin
                err_count <= '0;
            end else if (err_hit && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            bad <= (err_hit && (state_n == ST_LOCKED)) ? bad + 1'b1 : '0;
            if ((state_n == ST_LOCKED) && (state != ST_LOCKED)) begin
                latency <= hit_k;
            end
            for (int k = 0; k <= MAX_LATENCY; k++) begin
                if (restart || ((state == ST_LOCKED) && (state_n == ST_SEARCH))) begin
                    run[k] <= '0;
                end else if ((state == ST_SEARCH) && (state_n == ST_SEARCH)) begin
                    run[k] <= run_next[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_xgmii_loopback_tester.sv
// tb/tb_xgmii_loopback_tester.sv - scoreboard bench with programmable loopback delay and corruption
module tb_xgmii_loopback_tester;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic        cfg_clear;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        lock;
    logic [3:0]  latency;
    logic        err_pulse;
    logic [3:0]  err_count;

    logic [4:0]  dly;
    logic        corrupt;
    logic [71:0] dl [0:31];
    logic [71:0] dl_out;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;

    typedef struct {
        string       name;
        logic        lock;
        logic [3:0]  lat;
        logic [3:0]  cnt;
        bit          chk_tx;
        logic [63:0] txd;
        logic [7:0]  txc;
    } st_t;

    st_t        st_q[$];
    logic [3:0] err_q[$];

    xgmii_loopback_tester #(
        .ERR_CNT_WIDTH(4)
    ) dut (
        .tx_clk     (clk),
        .tx_rst     (rst),
        .cfg_enable (cfg_enable),
        .cfg_mode   (cfg_mode),
        .cfg_clear  (cfg_clear),
        .xgmii_txd  (txd),
        .xgmii_txc  (txc),
        .xgmii_rxd  (rxd),
        .xgmii_rxc  (rxc),
        .lock       (lock),
        .latency    (latency),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Loopback path: rx sees tx delayed by dly cycles.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) dl[i] <= {IDLE_D, 8'hFF};
        end else begin
            dl[0] <= {txd, txc};
            for (int i = 1; i < 32; i++) dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        dl_out = dl[dly - 5'd1];
        rxd    = corrupt ? (dl_out[71:8] ^ 64'h1) : dl_out[71:8];
        rxc    = dl_out[7:0];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (err_pulse) begin
                n_total++;
                if (err_q.size() == 0) begin
                    $display("FAIL unexpected_err_pulse: err_count=%0d, no pulse expected", err_count);
                end else begin
                    logic [3:0] e;
                    e = err_q.pop_front();
                    if (err_count == e) n_pass++;
                    else $display("FAIL err_pulse_count: err_count=%0d, expected %0d", err_count, e);
                end
            end
            if (st_q.size() != 0) begin
                st_t r;
                r = st_q.pop_front();
                n_total++;
                if (lock === r.lock && latency === r.lat && err_count === r.cnt &&
                    (!r.chk_tx || (txd === r.txd && txc === r.txc))) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: lock=%0d lat=%0d cnt=%0d txd=%h txc=%h, expected lock=%0d lat=%0d cnt=%0d txd=%h txc=%h (tx checked=%0d)",
                             r.name, lock, latency, err_count, txd, txc, r.lock, r.lat, r.cnt, r.txd, r.txc, r.chk_tx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input string n, input logic l, input logic [3:0] la, input logic [3:0] c,
                           input bit ct, input logic [63:0] d, input logic [7:0] cc);
        st_t r;
        r.name = n; r.lock = l; r.lat = la; r.cnt = c; r.chk_tx = ct; r.txd = d; r.txc = cc;
        st_q.push_back(r);
    endtask

    task automatic wait_lock(input string n, input int bound);
        int i;
        i = 0;
        while (!lock && i < bound) begin
            tick();
            i++;
        end
        n_total++;
        if (lock) n_pass++;
        else $display("FAIL %s: lock=0 after %0d cycles, expected lock=1", n, bound);
    endtask

    initial begin
        rst = 1'b1; cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_clear = 1'b0;
        corrupt = 1'b0; dly = 5'd2;
        repeat (3) tick();
        rst = 1'b0;
        push_st("reset_state", 0, 0, 0, 1, IDLE_D, 8'hFF);
        tick();

        cfg_enable = 1'b1;
        tick();
        push_st("mode0_first_word", 0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        wait_lock("lock_mode0", 200);
        push_st("mode0_locked", 1, 2, 0, 0, '0, '0);
        repeat (1000) tick();
        push_st("mode0_1000_cycles", 1, 2, 0, 0, '0, '0);

        corrupt = 1'b1;
        err_q.push_back(4'd1);
        tick();
        corrupt = 1'b0;
        push_st("single_flip", 1, 2, 1, 0, '0, '0);
        tick();

        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        corrupt = 1'b1;
        for (int i = 1; i <= 4; i++) err_q.push_back(4'(i));
        repeat (4) tick();
        corrupt = 1'b0;
        push_st("burst4_unlock", 0, 2, 4, 0, '0, '0);
        wait_lock("relock_mode0", 200);
        push_st("relock_same_latency", 1, 2, 4, 0, '0, '0);

        corrupt = 1'b1; cfg_clear = 1'b1;
        err_q.push_back(4'd0);
        tick();
        corrupt = 1'b0; cfg_clear = 1'b0;
        push_st("clear_coincident", 1, 2, 0, 0, '0, '0);
        tick();

        for (int b = 0; b < 6; b++) begin
            corrupt = 1'b1;
            for (int j = 1; j <= 3; j++) err_q.push_back(4'((3*b + j) > 15 ? 15 : (3*b + j)));
            repeat (3) tick();
            corrupt = 1'b0;
            tick();
        end
        push_st("saturate", 1, 2, 15, 0, '0, '0);

        cfg_mode = 2'd2; dly = 5'd5;
        tick();
        push_st("prbs_first_word", 0, 2, 15, 1, 64'h0000000E000000FC, 8'h00);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        wait_lock("lock_prbs", 200);
        push_st("prbs_locked", 1, 5, 0, 0, '0, '0);
        repeat (200) tick();
        push_st("prbs_stable", 1, 5, 0, 0, '0, '0);

        cfg_mode = 2'd1; dly = 5'd3;
        tick();
        push_st("count_word0", 0, 5, 0, 1, 64'h0000000000000000, 8'h00);
        tick();
        push_st("count_word1", 0, 5, 0, 1, 64'h0000000100000001, 8'h00);
        wait_lock("lock_count", 200);
        push_st("count_locked", 1, 3, 0, 0, '0, '0);

        cfg_mode = 2'd0; dly = 5'd20;
        repeat (300) tick();
        push_st("latency_out_of_range", 0, 3, 0, 0, '0, '0);

        cfg_mode = 2'd3; dly = 5'd2;
        repeat (200) tick();
        push_st("mode3_no_lock", 0, 3, 0, 1, IDLE_D, 8'hFF);

        cfg_mode = 2'd1;
        tick();
        wait_lock("lock_count_d2", 200);
        push_st("count_locked_d2", 1, 2, 0, 0, '0, '0);
        tick();
        corrupt = 1'b1;
        err_q.push_back(4'd1);
        tick();
        corrupt = 1'b0;
        tick();

        cfg_enable = 1'b0;
        tick();
        push_st("disabled", 0, 2, 1, 1, IDLE_D, 8'hFF);
        repeat (3) tick();

        n_total++;
        if (err_q.size() == 0 && st_q.size() == 0) n_pass++;
        else $display("FAIL queues_drained: err_q=%0d st_q=%0d left, expected 0 and 0", err_q.size(), st_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
